// File: rtl/vend_pkg.sv
// Shared coin encodings, coin values and dispenser FSM states.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_NICKEL  = 2'b00,
      COIN_DIME    = 2'b01,
      COIN_QUARTER = 2'b10
   } coin_t;

   localparam logic [7:0] VAL_NICKEL  = 8'd5;
   localparam logic [7:0] VAL_DIME    = 8'd10;
   localparam logic [7:0] VAL_QUARTER = 8'd25;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SELECT,
      ST_EJECT,
      ST_FINISH
   } state_t;

   function automatic logic [7:0] coin_value(input coin_t c);
      case (c)
         COIN_NICKEL:  return VAL_NICKEL;
         COIN_DIME:    return VAL_DIME;
         COIN_QUARTER: return VAL_QUARTER;
         default:      return 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_tube.sv
// One denomination tube: 6-bit coin count, loaded to TUBE_MAX on reset/refill,
// decremented per dispensed coin and saturating at zero.
module coin_tube #(
   parameter int TUBE_MAX = 20
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_dec,
   output logic o_empty
);

   logic [5:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_load) begin
         r_count <= 6'(TUBE_MAX);
      end else if (i_dec && (r_count != 6'd0)) begin
         r_count <= r_count - 6'd1;
      end
   end

   assign o_empty = (r_count == 6'd0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out quarters, dimes, nickels from finite tubes
// through a handshaked ejector, with ack timeout and short-change reporting.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int TUBE_MAX    = 20,
   parameter int ACK_TIMEOUT = 200
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic [7:0] i_amount,
   input  logic       i_coin_ack,
   input  logic       i_refill,
   output logic       o_coin_valid,
   output logic [1:0] o_coin_type,
   output logic       o_done,
   output logic       o_short,
   output logic       o_busy,
   output logic [7:0] o_remaining
);

   state_t     r_state;
   coin_t      r_coin_type;
   logic [7:0] r_remaining;
   logic [7:0] r_ack_cnt;
   logic       r_coin_valid;
   logic       r_done;
   logic       r_short;

   logic w_refill;
   logic w_ack;
   logic w_empty_n, w_empty_d, w_empty_q;
   logic w_can_n, w_can_d, w_can_q;

   // Tubes only reload while idle, and only count a coin the ejector took.
   assign w_refill = (r_state == ST_IDLE) && i_refill;
   assign w_ack    = (r_state == ST_EJECT) && i_coin_ack;

   coin_tube #(.TUBE_MAX(TUBE_MAX)) u_tube_nickel (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_refill),
      .i_dec   (w_ack && (r_coin_type == COIN_NICKEL)),
      .o_empty (w_empty_n)
   );

   coin_tube #(.TUBE_MAX(TUBE_MAX)) u_tube_dime (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_refill),
      .i_dec   (w_ack && (r_coin_type == COIN_DIME)),
      .o_empty (w_empty_d)
   );

   coin_tube #(.TUBE_MAX(TUBE_MAX)) u_tube_quarter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_refill),
      .i_dec   (w_ack && (r_coin_type == COIN_QUARTER)),
      .o_empty (w_empty_q)
   );

   assign w_can_q = !w_empty_q && (r_remaining >= VAL_QUARTER);
   assign w_can_d = !w_empty_d && (r_remaining >= VAL_DIME);
   assign w_can_n = !w_empty_n && (r_remaining >= VAL_NICKEL);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_coin_type  <= COIN_NICKEL;
         r_remaining  <= 8'd0;
         r_ack_cnt    <= 8'd0;
         r_coin_valid <= 1'b0;
         r_done       <= 1'b0;
         r_short      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start && !r_done) begin
                  r_remaining <= i_amount;
                  r_ack_cnt   <= 8'd0;
                  r_state     <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               r_ack_cnt <= 8'd0;
               if (w_can_q || w_can_d || w_can_n) begin
                  r_coin_type  <= w_can_q ? COIN_QUARTER :
                                  w_can_d ? COIN_DIME : COIN_NICKEL;
                  r_coin_valid <= 1'b1;
                  r_state      <= ST_EJECT;
               end else begin
                  r_done  <= 1'b1;
                  r_short <= (r_remaining != 8'd0);
                  r_state <= ST_FINISH;
               end
            end
            ST_EJECT: begin
               // Selection guarantees value <= remaining, so no underflow here.
               if (i_coin_ack) begin
                  r_remaining  <= r_remaining - coin_value(r_coin_type);
                  r_coin_valid <= 1'b0;
                  r_state      <= ST_SELECT;
               end else if (r_ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
                  r_coin_valid <= 1'b0;
                  r_done       <= 1'b1;
                  r_short      <= (r_remaining != 8'd0);
                  r_state      <= ST_FINISH;
               end else begin
                  r_ack_cnt <= r_ack_cnt + 8'd1;
               end
            end
            ST_FINISH: begin
               if (!i_start) begin
                  r_done  <= 1'b0;
                  r_short <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_coin_valid = r_coin_valid;
   assign o_coin_type  = r_coin_type;
   assign o_done       = r_done;
   assign o_short      = r_short;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_remaining  = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy coin-tube reference model.
module tb_change_dispenser;

   localparam int TMAX = 20;
   localparam int TOUT = 200;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, ack, refill;
   logic [7:0] amount;
   logic       cv, done, shrt, busy;
   logic [1:0] ct;
   logic [7:0] rem;

   logic       rst1_n, start1, ack1, refill1;
   logic [7:0] amount1;
   logic       cv1, done1, shrt1, busy1;
   logic [1:0] ct1;
   logic [7:0] rem1;

   change_dispenser dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_amount(amount),
      .i_coin_ack(ack), .i_refill(refill), .o_coin_valid(cv), .o_coin_type(ct),
      .o_done(done), .o_short(shrt), .o_busy(busy), .o_remaining(rem)
   );

   change_dispenser #(.TUBE_MAX(1), .ACK_TIMEOUT(5)) dut1 (
      .i_clk(clk), .i_rst_n(rst1_n), .i_start(start1), .i_amount(amount1),
      .i_coin_ack(ack1), .i_refill(refill1), .o_coin_valid(cv1), .o_coin_type(ct1),
      .o_done(done1), .o_short(shrt1), .o_busy(busy1), .o_remaining(rem1)
   );

   int errors = 0;
   int checks = 0;
   int tube[3];
   int exp_q[$];
   int got_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int dut_tube(input int k);
      case (k)
         0:       return int'(dut.u_tube_nickel.r_count);
         1:       return int'(dut.u_tube_dime.r_count);
         default: return int'(dut.u_tube_quarter.r_count);
      endcase
   endfunction

   function automatic bit same_coins(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Greedy payout from whatever the tubes hold, assuming every coin is accepted.
   task automatic model_txn(input int amt, output int rem_out);
      int r;
      r = amt;
      exp_q.delete();
      forever begin
         if (r >= 25 && tube[2] > 0) begin exp_q.push_back(2); r -= 25; tube[2]--; end
         else if (r >= 10 && tube[1] > 0) begin exp_q.push_back(1); r -= 10; tube[1]--; end
         else if (r >= 5 && tube[0] > 0) begin exp_q.push_back(0); r -= 5; tube[0]--; end
         else break;
      end
      rem_out = r;
   endtask

   task automatic refill_idle();
      refill = 1'b1;
      tick();
      refill = 1'b0;
      for (int k = 0; k < 3; k++) tube[k] = TMAX;
   endtask

   // One full transaction on the main DUT; dly<0 picks a random ack delay per coin.
   task automatic run_txn(input int amt, input int dly, input bit drop_start,
                          input bit noise, output int done_cyc);
      int exp_rem, c, first_cv, hi, d;
      bit fin;
      logic [1:0] prev_ct;
      model_txn(amt, exp_rem);
      got_q.delete();
      amount = 8'(amt);
      start  = 1'b1;
      tick();
      if (drop_start) start = 1'b0;
      first_cv = -1; hi = 0; fin = 1'b0; c = 0; done_cyc = -1; prev_ct = 2'b00;
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      while (!fin && c < 3000) begin
         tick();
         c++;
         ack = 1'b0;
         refill = 1'b0;
         if (cv) begin
            if (first_cv < 0) first_cv = c;
            if (hi > 0) begin
               checks++;
               if (ct !== prev_ct) begin
                  errors++;
                  $display("FAIL coin_type_stable: got %0d expected %0d", ct, prev_ct);
               end
            end
            prev_ct = ct;
            if (hi == d) begin
               got_q.push_back(int'(ct));
               ack = 1'b1;
               hi = 0;
               d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            end else begin
               hi++;
            end
         end else if (done) begin
            fin = 1'b1;
            done_cyc = c;
         end else if (noise) begin
            ack    = ($urandom_range(0, 3) == 0);
            refill = ($urandom_range(0, 3) == 0);
         end
      end
      ack = 1'b0;
      refill = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL txn_done_timeout: amount %0d never reached done", amt);
      end
      checks++;
      if (!same_coins(got_q, exp_q)) begin
         errors++;
         $display("FAIL txn_coins: amount %0d got %0d coins expected %0d coins", amt, got_q.size(), exp_q.size());
      end
      checks++;
      if (rem !== 8'(exp_rem) || shrt !== (exp_rem != 0)) begin
         errors++;
         $display("FAIL txn_remaining: amount %0d got rem=%0d short=%0b expected rem=%0d short=%0b",
                  amt, rem, shrt, exp_rem, exp_rem != 0);
      end
      checks++;
      if (first_cv !== ((exp_q.size() > 0) ? 1 : -1)) begin
         errors++;
         $display("FAIL txn_latency: first coin_valid cycle got %0d expected %0d",
                  first_cv, (exp_q.size() > 0) ? 1 : -1);
      end
      start = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || shrt !== 1'b0) begin
         errors++;
         $display("FAIL txn_release: got done=%0b busy=%0b short=%0b expected 0 0 0", done, busy, shrt);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dut_tube(k) !== tube[k]) begin
            errors++;
            $display("FAIL tube_count[%0d]: got %0d expected %0d", k, dut_tube(k), tube[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; ack = 1'b0; refill = 1'b0; amount = 8'd0;
      rst1_n = 1'b0; start1 = 1'b0; ack1 = 1'b0; refill1 = 1'b0; amount1 = 8'd0;
      tick();
      tick();
      checks++;
      if ({cv, done, shrt, busy, ct, rem} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: got cv=%0b done=%0b short=%0b busy=%0b type=%0d rem=%0d expected all 0",
                  cv, done, shrt, busy, ct, rem);
      end
      for (int k = 0; k < 3; k++) begin
         tube[k] = TMAX;
         checks++;
         if (dut_tube(k) !== TMAX) begin
            errors++;
            $display("FAIL reset_tube[%0d]: got %0d expected %0d", k, dut_tube(k), TMAX);
         end
      end
      rst_n = 1'b1;
      rst1_n = 1'b1;
      tick();
   endtask

   task automatic test_change_40();
      int dc;
      int want[$];
      want = '{2, 1, 0};
      refill_idle();
      run_txn(40, 1, 1'b0, 1'b0, dc);
      checks++;
      if (!same_coins(got_q, want)) begin
         errors++;
         $display("FAIL change_40_sequence: got %0d coins expected quarter,dime,nickel", got_q.size());
      end
   endtask

   task automatic test_zero();
      int dc;
      run_txn(0, 0, 1'b0, 1'b0, dc);
      checks++;
      if (dc !== 1) begin
         errors++;
         $display("FAIL zero_done_latency: got %0d expected 1", dc);
      end
   endtask

   task automatic test_odd_7();
      int dc;
      refill_idle();
      run_txn(7, 0, 1'b0, 1'b0, dc);
      checks++;
      if (rem !== 8'd0 && got_q.size() !== 1) begin
         errors++;
         $display("FAIL odd_7_coins: got %0d expected 1", got_q.size());
      end
   endtask

   task automatic test_timeout();
      int n_hi, c;
      refill_idle();
      amount = 8'd30;
      start  = 1'b1;
      tick();
      n_hi = 0; c = 0;
      while (!done && c < 1000) begin
         tick();
         c++;
         if (cv) n_hi++;
      end
      checks++;
      if (n_hi !== TOUT) begin
         errors++;
         $display("FAIL timeout_valid_cycles: got %0d expected %0d", n_hi, TOUT);
      end
      checks++;
      if (done !== 1'b1 || shrt !== 1'b1 || rem !== 8'd30) begin
         errors++;
         $display("FAIL timeout_result: got done=%0b short=%0b rem=%0d expected 1 1 30", done, shrt, rem);
      end
      checks++;
      if (dut_tube(2) !== TMAX) begin
         errors++;
         $display("FAIL timeout_no_decrement: got %0d expected %0d", dut_tube(2), TMAX);
      end
      start = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int dc, amt;
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0) refill_idle();
         amt = int'($urandom_range(0, 255));
         run_txn(amt, -1, 1'($urandom_range(0, 1)), 1'b1, dc);
      end
   endtask

   task automatic test_reset_mid_eject();
      int c;
      refill_idle();
      amount = 8'd30;
      start  = 1'b1;
      tick();
      c = 0;
      while (!cv && c < 10) begin
         tick();
         c++;
      end
      checks++;
      if (cv !== 1'b1) begin
         errors++;
         $display("FAIL mid_eject_reach: got coin_valid=%0b expected 1", cv);
      end
      ack   = 1'b1;
      rst_n = 1'b0;
      tick();
      checks++;
      if (cv !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rem !== 8'd0) begin
         errors++;
         $display("FAIL mid_eject_reset: got cv=%0b done=%0b busy=%0b rem=%0d expected 0 0 0 0", cv, done, busy, rem);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dut_tube(k) !== TMAX) begin
            errors++;
            $display("FAIL mid_eject_tube[%0d]: got %0d expected %0d", k, dut_tube(k), TMAX);
         end
      end
      ack = 1'b0; start = 1'b0; rst_n = 1'b1;
      tick();
   endtask

   // Drives one transaction on the TUBE_MAX=1 / ACK_TIMEOUT=5 instance.
   task automatic dut1_txn(input int amt, input bit do_ack, output int n_hi, output bit fin);
      int c;
      got_q.delete();
      amount1 = 8'(amt);
      start1  = 1'b1;
      tick();
      n_hi = 0; c = 0; fin = 1'b0;
      while (!fin && c < 200) begin
         tick();
         c++;
         ack1 = 1'b0;
         if (cv1) begin
            n_hi++;
            if (do_ack) begin
               got_q.push_back(int'(ct1));
               ack1 = 1'b1;
            end
         end else if (done1) begin
            fin = 1'b1;
         end
      end
      ack1 = 1'b0;
   endtask

   task automatic test_small_tubes();
      int n_hi;
      bit fin;
      int want[$];
      want = '{2, 1, 0};
      dut1_txn(60, 1'b1, n_hi, fin);
      checks++;
      if (!fin || !same_coins(got_q, want)) begin
         errors++;
         $display("FAIL small_60_coins: got fin=%0b coins=%0d expected fin=1 coins=3", fin, got_q.size());
      end
      checks++;
      if (shrt1 !== 1'b1 || rem1 !== 8'd20) begin
         errors++;
         $display("FAIL small_60_result: got short=%0b rem=%0d expected 1 20", shrt1, rem1);
      end
      start1 = 1'b0;
      tick();
      checks++;
      if (done1 !== 1'b0) begin
         errors++;
         $display("FAIL small_release: got done=%0b expected 0", done1);
      end
      dut1_txn(10, 1'b1, n_hi, fin);
      checks++;
      if (!fin || n_hi !== 0 || shrt1 !== 1'b1 || rem1 !== 8'd10) begin
         errors++;
         $display("FAIL small_empty: got coins=%0d short=%0b rem=%0d expected 0 1 10", n_hi, shrt1, rem1);
      end
      start1 = 1'b0;
      tick();
      refill1 = 1'b1;
      tick();
      refill1 = 1'b0;
      dut1_txn(5, 1'b0, n_hi, fin);
      checks++;
      if (!fin || n_hi !== 5 || shrt1 !== 1'b1 || rem1 !== 8'd5) begin
         errors++;
         $display("FAIL small_timeout: got valid_cycles=%0d short=%0b rem=%0d expected 5 1 5", n_hi, shrt1, rem1);
      end
      start1 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_change_40();
      test_zero();
      test_odd_7();
      test_timeout();
      test_random();
      test_reset_mid_eject();
      test_small_tubes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter TUBE_MAX, default 20, SHALL set the coins per denomination tube after reset/refill (1..63).
REQ-002 Parameter ACK_TIMEOUT, default 200, SHALL set the max cycles EJECT waits for coin_ack (1..255).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-005 start  in  1  SHALL be the level request to return change (driven by the vending FSM's cancelled).
REQ-006 amount  in  8  SHALL be the change owed in cents, unsigned.
REQ-007 coin_ack  in  1  SHALL be the ejector accepting the presented coin.
REQ-008 refill  in  1  SHALL be the request to reload all tubes to TUBE_MAX.
REQ-009 coin_valid  out  1  SHALL be high while a coin is presented to the ejector.
REQ-010 coin_type  out  2  SHALL be the presented denomination: 00 nickel(5), 01 dime(10), 10 quarter(25).
REQ-011 done  out  1  SHALL be the completion flag (feeds the vending FSM's cancelledDone).
REQ-012 short  out  1  SHALL be high with done when remaining is nonzero.
REQ-013 busy  out  1  SHALL be high in any state other than IDLE.
REQ-014 remaining  out  8  SHALL be the cents still owed.

Function
REQ-015 FSM states SHALL be IDLE, SELECT, EJECT, FINISH.
REQ-016 In IDLE, start=1 and done=0: remaining<=amount, ack counter cleared, next SELECT.
REQ-017 SELECT, one cycle: choose the largest coin with value<=remaining and tube count>0 (quarter, then dime, then nickel), register coin_type, next EJECT; if none qualifies, next FINISH.
REQ-018 Latency: coin_valid SHALL rise 2 cycles after the cycle start is sampled in IDLE.
REQ-019 EJECT: coin_valid=1, coin_type stable; on coin_ack=1: remaining -= coin value, that tube decrements by 1, next SELECT, coin_valid low for one cycle.
REQ-020 EJECT without coin_ack for ACK_TIMEOUT consecutive cycles: next FINISH, no decrement.
REQ-021 FINISH: done=1; short=(remaining!=0); both held until start=0, then cleared, next IDLE.
REQ-022 start deassert before FINISH SHALL be ignored; a started transaction always completes.
REQ-023 amount=0: SELECT finds no coin, FINISH with short=0, no coin_valid pulse.
REQ-024 Non-multiple-of-5 amounts: residual <5 SHALL terminate with short=1.
REQ-025 refill SHALL be honoured only in IDLE; ignored elsewhere.
REQ-026 Tube counters SHALL saturate at 0; a tube at 0 SHALL never be selected.
REQ-027 Subtraction SHALL be 8-bit and never underflow (guaranteed by REQ-017).
REQ-028 coin_ack outside EJECT SHALL be ignored.

Reset
REQ-029 rst_n=0 at any clock edge, including mid-EJECT: state IDLE, remaining=0, all outputs 0, tubes=TUBE_MAX, ack counter 0.
REQ-030 A coin presented when reset hits SHALL NOT be counted as dispensed.

Structure
REQ-031 Package vend_pkg SHALL hold coin_type encodings, coin values (5/10/25), and the FSM state enum.
REQ-032 Sub-module coin_tube (6-bit load/decrement counter with empty flag) SHALL be instantiated once per denomination.

Verification
REQ-033 amount=40, full tubes, ack 1 cycle after each coin_valid -> quarter, dime, nickel; done=1, short=0, remaining=0.
REQ-034 amount=0 -> no coin_valid; done=1 two cycles after start; done clears one cycle after start=0.
REQ-035 TUBE_MAX=1, amount=60 -> quarter, dime, nickel dispensed; done=1, short=1, remaining=20.
REQ-036 amount=30, coin_ack held 0 -> coin_valid high for exactly ACK_TIMEOUT cycles; then done=1, short=1, remaining=30.
REQ-037 amount=7 -> one nickel; done=1, short=1, remaining=2.
REQ-038 rst_n=0 during EJECT -> next cycle IDLE, coin_valid=0, done=0, tubes back to TUBE_MAX.
